// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the instruction decode side and pc_sequencer:
// control/event inputs from decode, fetch addresses and status back out.
interface pc_sequencer_if;
    logic        stall;
    logic        halt_req;
    logic        resume;
    logic        br_valid;
    logic        br_taken;
    logic        br_always;
    logic        br_annul;
    logic [31:0] br_disp;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        trap_req;

    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] next_pc;
    logic        pc_we;
    logic        fetch_valid;
    logic        annul_slot;
    logic        trap_taken;
    logic [31:0] epc;
    logic        halted;

    modport master (
        output stall, halt_req, resume, br_valid, br_taken, br_always, br_annul,
               br_disp, jmp_valid, jmp_target, trap_req,
        input  pc, npc, next_pc, pc_we, fetch_valid, annul_slot, trap_taken,
               epc, halted
    );

    modport slave (
        input  stall, halt_req, resume, br_valid, br_taken, br_always, br_annul,
               br_disp, jmp_valid, jmp_target, trap_req,
        output pc, npc, next_pc, pc_we, fetch_valid, annul_slot, trap_taken,
               epc, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// SPARC-style PC/nPC sequencer: picks sequential, branch, call/jmpl or trap
// fetch addresses each cycle and drives the Program_Counter update.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned PC_STEP      = 4
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);
    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pc_r;
    logic [31:0] npc_r;
    logic [31:0] epc_r;
    logic        annul_r;
    logic        trap_taken_r;

    logic [31:0] next_pc_c;
    logic [31:0] next_npc_c;
    logic [31:0] branch_target;
    logic        events_live;
    logic        jmp_misaligned;
    logic        take_trap;
    logic        advance;
    logic        annul_next;
    logic        pc_we_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // An annulled delay slot masks branch, jump and trap inputs entirely.
    always_comb begin
        events_live    = !annul_r;
        jmp_misaligned = bus.jmp_valid && (bus.jmp_target[1:0] != 2'b00);
        branch_target  = pc_r + {bus.br_disp[29:0], 2'b00};
        take_trap      = 1'b0;
        advance        = 1'b0;
        case (state)
            RUN: begin
                take_trap = events_live && (bus.trap_req || jmp_misaligned);
                advance   = !take_trap && !bus.stall && !bus.halt_req;
            end
            HALT: begin
                take_trap = bus.trap_req;
            end
            default: begin
            end
        endcase
        annul_next = bus.br_valid && events_live && bus.br_annul &&
                     (!bus.br_taken || bus.br_always);
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (!take_trap && !bus.stall && bus.halt_req) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (bus.trap_req || bus.resume) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        pc_we_c    = take_trap || advance;
        next_pc_c  = pc_r;
        next_npc_c = npc_r + STEP;
        if (take_trap) begin
            next_pc_c  = TRAP_VECTOR;
            next_npc_c = TRAP_VECTOR + STEP;
        end else if (advance) begin
            next_pc_c = npc_r;
            if (events_live && bus.jmp_valid) begin
                next_npc_c = bus.jmp_target;
            end else if (events_live && bus.br_valid && bus.br_taken) begin
                next_npc_c = branch_target;
            end
        end
    end

    // Stalls and halt entry leave the annul flag alone so the held slot keeps its status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r         <= RESET_VECTOR;
            npc_r        <= RESET_VECTOR + STEP;
            epc_r        <= 32'h0000_0000;
            annul_r      <= 1'b0;
            trap_taken_r <= 1'b0;
        end else begin
            trap_taken_r <= take_trap;
            if (pc_we_c) begin
                pc_r  <= next_pc_c;
                npc_r <= next_npc_c;
            end
            if (take_trap) begin
                epc_r   <= pc_r;
                annul_r <= 1'b0;
            end else if (advance) begin
                annul_r <= annul_next;
            end
        end
    end

    assign bus.pc          = pc_r;
    assign bus.npc         = npc_r;
    assign bus.next_pc     = next_pc_c;
    assign bus.pc_we       = pc_we_c;
    assign bus.fetch_valid = (state == RUN) && !annul_r;
    assign bus.annul_slot  = annul_r;
    assign bus.trap_taken  = trap_taken_r;
    assign bus.epc         = epc_r;
    assign bus.halted      = (state == HALT);

endmodule
